// File: rtl/ifetch_pkg.sv
// Shared types and geometry for the instruction fetch window.
package ifetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        OUT   = 1'b1
    } state_t;

    localparam int LINE_BYTES = 8;
    localparam int INST_BYTES = 10;
    localparam int LINE_OFF_W = 3;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int INST_W     = INST_BYTES * 8;

endpackage

// File: rtl/ifetch_window_align.sv
// Byte aligner: picks the 10-byte window at offset i_off out of three
// consecutive lines {L2,L1,L0}, or forces zero.
module ifetch_align
    import ifetch_pkg::*;
(
    input  logic [3*LINE_W-1:0]   i_lines,
    input  logic [LINE_OFF_W-1:0] i_off,
    input  logic                  i_zero,
    output logic [INST_W-1:0]     o_inst
);

    logic [3*LINE_W-1:0] w_shift;

    assign w_shift = i_lines >> {i_off, 3'b000};
    assign o_inst  = i_zero ? '0 : w_shift[INST_W-1:0];

endmodule

// File: rtl/ifetch_window.sv
// Fetch stage: reads the 2-3 aligned lines covering the 10 bytes at PC and
// presents them to decode. Optional IFETCH_LINE_REUSE_EN keeps overlapping lines.
module ifetch_window
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [LINE_W-1:0] imem_rdata,
    input  logic              imem_err,
    output logic [INST_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc,
    output logic              inst_valid,
    output logic              imem_error,
    input  logic              inst_ready,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              halt
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_pc;
    logic [2:0][LINE_W-1:0]  r_line;
    logic [2:0]              r_v;
    logic                    r_err;

    logic [ADDR_W-1:0]       w_base;
    logic                    w_need2;
    logic [2:0]              w_miss;
    logic [1:0]              w_sel;
    logic                    w_last;
    logic                    w_req;
    logic                    w_ack;
    logic                    w_accept;
    logic [2:0]              w_v_keep;
    logic [2:0][LINE_W-1:0]  w_line_keep;

    assign w_base  = {r_pc[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    assign w_need2 = &r_pc[LINE_OFF_W-1:0];
    assign w_miss  = {w_need2 & ~r_v[2], ~r_v[1], ~r_v[0]};

    always_comb begin
        w_sel = 2'd0;
        if (!w_miss[0])
            w_sel = w_miss[1] ? 2'd1 : 2'd2;
    end

    // The line being fetched is the final one when nothing else is missing.
    assign w_last = ((w_miss & ~(3'b001 << w_sel)) == 3'b000);

    // Gating with rst_n drops the request asynchronously on reset.
    assign w_req     = rst_n & (r_state == FETCH) & (|w_miss);
    assign w_ack     = w_req & imem_ack;
    assign w_accept  = (r_state == OUT) & inst_ready & ~halt;

    assign imem_req  = w_req;
    assign imem_addr = w_req ? (w_base + ADDR_W'({w_sel, 3'b000})) : '0;

`ifdef IFETCH_LINE_REUSE_EN
    logic [ADDR_W-LINE_OFF_W-1:0] w_d;

    assign w_d = next_pc[ADDR_W-1:LINE_OFF_W] - r_pc[ADDR_W-1:LINE_OFF_W];

    always_comb begin
        w_v_keep    = '0;
        w_line_keep = r_line;
        if (!r_err) begin
            if (w_d == '0) begin
                w_v_keep = r_v;
            end else if (w_d == (ADDR_W-LINE_OFF_W)'(1)) begin
                w_v_keep    = {1'b0, r_v[2:1]};
                w_line_keep = {r_line[2], r_line[2], r_line[1]};
            end else if (w_d == (ADDR_W-LINE_OFF_W)'(2)) begin
                w_v_keep    = {2'b00, r_v[2]};
                w_line_keep = {r_line[2], r_line[1], r_line[2]};
            end
        end
    end
`else
    assign w_v_keep    = '0;
    assign w_line_keep = r_line;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FETCH;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH: begin
                // With every needed line retained this is a request-free bubble.
                if (!(|w_miss))
                    w_state_nxt = OUT;
                else if (w_ack && (imem_err || w_last))
                    w_state_nxt = OUT;
            end
            OUT: begin
                if (w_accept)
                    w_state_nxt = FETCH;
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= RESET_PC;
            r_line <= '0;
            r_v    <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_ack) begin
                if (imem_err) begin
                    r_err <= 1'b1;
                end else begin
                    r_line[w_sel] <= imem_rdata;
                    r_v[w_sel]    <= 1'b1;
                end
            end
            if (w_accept) begin
                r_pc   <= next_pc;
                r_err  <= 1'b0;
                r_v    <= w_v_keep;
                r_line <= w_line_keep;
            end
        end
    end

    ifetch_align u_align (
        .i_lines (r_line),
        .i_off   (r_pc[LINE_OFF_W-1:0]),
        .i_zero  (r_err | (r_state != OUT)),
        .o_inst  (instruction)
    );

    assign pc         = r_pc;
    assign inst_valid = (r_state == OUT);
    assign imem_error = (r_state == OUT) & r_err;

endmodule

// File: tb/tb_ifetch_window.sv
// Self-checking bench for ifetch_window: directed scenarios plus a randomized
// run against an address-level model of the fetch window.
module tb_ifetch_window;

    localparam logic [63:0] SPECIAL = 64'hC3B2_0000_0A00_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [63:0] imem_rdata;
    logic        imem_err;
    logic [79:0] instruction;
    logic [63:0] pc;
    logic        inst_valid;
    logic        imem_error;
    logic        inst_ready;
    logic [63:0] next_pc;
    logic        halt;

    int          ack_delay = 0;
    int          wcnt = 0;
    bit          err_en = 1'b0;
    logic [63:0] err_addr = '0;
    logic [63:0] reads[$];
    int          n_checks = 0;
    int          n_fail = 0;

    // model state
    logic [63:0] m_pc;
    logic [63:0] mv[$];
    bit          m_err;

    ifetch_window #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .instruction (instruction),
        .pc          (pc),
        .inst_valid  (inst_valid),
        .imem_error  (imem_error),
        .inst_ready  (inst_ready),
        .next_pc     (next_pc),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mbyte(input logic [63:0] a);
        logic [63:0] sp;
        logic [7:0]  h;
        sp = SPECIAL;
        if (a[63:3] == '0) return sp[8*a[2:0] +: 8];
        h = a[7:0] * 8'd37;
        return h ^ a[15:8] ^ a[63:56] ^ 8'h5A;
    endfunction

    function automatic logic [79:0] exp_inst(input logic [63:0] p);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r[8*k +: 8] = mbyte(p + 64'(k));
        return r;
    endfunction

    function automatic bit q_eq(input logic [63:0] a[$], input logic [63:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q_fmt(input logic [63:0] a[$]);
        string s;
        s = "{";
        foreach (a[i]) s = {s, $sformatf(" %0h", a[i])};
        return {s, " }"};
    endfunction

    function automatic bit in_q(input logic [63:0] q[$], input logic [63:0] a);
        foreach (q[i]) if (q[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // memory responder: ack after ack_delay waiting cycles, possibly the same cycle
    always @(posedge clk) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end
    assign imem_ack = imem_req && (wcnt >= ack_delay);
    assign imem_err = err_en && (imem_addr == err_addr);
    always_comb begin
        imem_rdata = '0;
        for (int k = 0; k < 8; k++) imem_rdata[8*k +: 8] = mbyte({imem_addr[63:3], 3'(k)});
    end

    // completed reads, sampled with pre-edge values
    always @(posedge clk) begin
        if (rst_n && imem_req && imem_ack) reads.push_back(imem_addr);
    end

    task automatic wait_valid(output int n);
        n = 0;
        while (!inst_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept(input logic [63:0] npc);
        inst_ready = 1'b1;
        next_pc    = npc;
        @(posedge clk);
        #1 inst_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        int n;
        logic [63:0] e[$];
        rst_n = 1'b0; inst_ready = 1'b0; halt = 1'b0; next_pc = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({imem_req, inst_valid, imem_error} !== 3'b000 || imem_addr !== '0 ||
            instruction !== '0 || pc !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b valid=%b err=%b addr=%h inst=%h pc=%h, want all 0",
                     imem_req, inst_valid, imem_error, imem_addr, instruction, pc);
        end
        #1 rst_n = 1'b1;
        wait_valid(n);
        n_checks++;
        if (!inst_valid || n != 2) begin
            n_fail++; $display("FAIL first_latency: valid=%b after %0d edges, want 1 after 2", inst_valid, n);
        end
        e = '{64'h0, 64'h8};
        n_checks++;
        if (!q_eq(reads, e)) begin
            n_fail++; $display("FAIL first_reads: got %s want %s", q_fmt(reads), q_fmt(e));
        end
        n_checks++;
        if (instruction[15:0] !== SPECIAL[15:0] || instruction !== exp_inst(64'h0) || pc !== 64'h0) begin
            n_fail++;
            $display("FAIL first_inst: got inst=%h pc=%h want inst=%h pc=0", instruction, pc, exp_inst(64'h0));
        end
    endtask

    task automatic test_offset7;
        int n;
        logic [63:0] e[$];
        reads.delete();
        accept(64'h17);
        wait_valid(n);
        e = '{64'h10, 64'h18, 64'h20};
        n_checks++;
        if (!q_eq(reads, e)) begin
            n_fail++; $display("FAIL off7_reads: got %s want %s", q_fmt(reads), q_fmt(e));
        end
        n_checks++;
        if (instruction[7:0] !== mbyte(64'h17) || instruction[79:72] !== mbyte(64'h20)) begin
            n_fail++;
            $display("FAIL off7_edges: got lo=%h hi=%h want lo=%h hi=%h",
                     instruction[7:0], instruction[79:72], mbyte(64'h17), mbyte(64'h20));
        end
        n_checks++;
        if (!inst_valid || instruction !== exp_inst(64'h17) || pc !== 64'h17) begin
            n_fail++;
            $display("FAIL off7_inst: got v=%b inst=%h pc=%h want inst=%h pc=17",
                     inst_valid, instruction, pc, exp_inst(64'h17));
        end
    endtask

    task automatic test_error;
        int n;
        logic [63:0] e[$];
        err_en = 1'b1; err_addr = 64'h8;
        reads.delete();
        accept(64'h7);
        wait_valid(n);
        e = '{64'h0, 64'h8};
        n_checks++;
        if (!q_eq(reads, e)) begin
            n_fail++; $display("FAIL err_reads: got %s want %s", q_fmt(reads), q_fmt(e));
        end
        n_checks++;
        if (!inst_valid || imem_error !== 1'b1 || instruction !== '0) begin
            n_fail++;
            $display("FAIL err_out: got v=%b err=%b inst=%h want v=1 err=1 inst=0", inst_valid, imem_error, instruction);
        end
        err_en = 1'b0;
        reads.delete();
        accept(64'h20);
        wait_valid(n);
        e = '{64'h20, 64'h28};
        n_checks++;
        if (imem_error !== 1'b0 || instruction !== exp_inst(64'h20) || !q_eq(reads, e)) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b inst=%h reads=%s want err=0 inst=%h reads=%s",
                     imem_error, instruction, q_fmt(reads), exp_inst(64'h20), q_fmt(e));
        end
    endtask

    task automatic test_halt;
        int n;
        logic [79:0] s_inst;
        logic [63:0] s_pc;
        s_inst = instruction; s_pc = pc;
        inst_ready = 1'b1; halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (!inst_valid || pc !== s_pc || instruction !== s_inst || imem_req) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: got v=%b pc=%h inst=%h req=%b want v=1 pc=%h inst=%h req=0",
                         i, inst_valid, pc, instruction, imem_req, s_pc, s_inst);
            end
        end
        halt = 1'b0; next_pc = 64'h48;
        @(posedge clk);
        #1 inst_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pc !== 64'h48 || inst_valid) begin
            n_fail++; $display("FAIL halt_release: got pc=%h v=%b want pc=48 v=0", pc, inst_valid);
        end
        // halt during fetch: reads still complete, then the window is held
        halt = 1'b1; inst_ready = 1'b1; ack_delay = 2;
        wait_valid(n);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (!inst_valid || pc !== 64'h48 || instruction !== exp_inst(64'h48)) begin
            n_fail++;
            $display("FAIL halt_fetch: got v=%b pc=%h inst=%h want v=1 pc=48 inst=%h",
                     inst_valid, pc, instruction, exp_inst(64'h48));
        end
        halt = 1'b0; inst_ready = 1'b0; ack_delay = 0;
    endtask

    task automatic test_delay_reset;
        int n;
        logic [63:0] e[$];
        ack_delay = 4;
        accept(64'h40);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'h40 || imem_ack) begin
                n_fail++;
                $display("FAIL delay_hold[%0d]: got req=%b addr=%h ack=%b want req=1 addr=40 ack=0",
                         i, imem_req, imem_addr, imem_ack);
            end
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        reads.delete();
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== '0 || pc !== '0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got req=%b addr=%h pc=%h v=%b want all 0", imem_req, imem_addr, pc, inst_valid);
        end
        ack_delay = 0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_valid(n);
        e = '{64'h0, 64'h8};
        n_checks++;
        if (!inst_valid || pc !== '0 || instruction !== exp_inst(64'h0) || !q_eq(reads, e)) begin
            n_fail++;
            $display("FAIL restart: got v=%b pc=%h inst=%h reads=%s want pc=0 inst=%h reads=%s",
                     inst_valid, pc, instruction, q_fmt(reads), exp_inst(64'h0), q_fmt(e));
        end
    endtask

    task automatic test_random;
        int n;
        logic [63:0] npc, nbase, d, la;
        logic [63:0] e[$];
        logic [63:0] keep[$];
        bit need2, xerr;
        m_pc = '0; mv = '{64'h0, 64'h8}; m_err = 1'b0;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       npc = m_pc + 64'($urandom_range(0, 24));
                1:       npc = {32'h0, $urandom()};
                2:       npc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: npc = m_pc - 64'($urandom_range(0, 16));
            endcase
            nbase = {npc[63:3], 3'b000};
            need2 = (npc[2:0] == 3'd7);
            err_en   = ($urandom_range(0, 5) == 0);
            err_addr = nbase + 64'(8 * $urandom_range(0, need2 ? 2 : 1));
            ack_delay = $urandom_range(0, 2);
`ifdef IFETCH_LINE_REUSE_EN
            d = ((npc >> 3) - (m_pc >> 3)) & 64'h1FFF_FFFF_FFFF_FFFF;
            if (m_err || d > 2) begin
                mv.delete();
            end else begin
                keep.delete();
                foreach (mv[i]) if (mv[i] - nbase < 64'd24) keep.push_back(mv[i]);
                mv = keep;
            end
`else
            d = '0;
            mv.delete();
`endif
            e.delete(); xerr = 1'b0;
            for (int i = 0; i < (need2 ? 3 : 2); i++) begin
                la = nbase + 64'(8 * i);
                if (in_q(mv, la)) continue;
                e.push_back(la);
                if (err_en && la == err_addr) begin
                    xerr = 1'b1;
                    break;
                end
                mv.push_back(la);
            end
            m_pc = npc; m_err = xerr;
            reads.delete();
            accept(npc);
            wait_valid(n);
            n_checks++;
            if (!q_eq(reads, e)) begin
                n_fail++;
                $display("FAIL rand_reads[%0d]: pc=%h d=%0h got %s want %s", it, npc, d, q_fmt(reads), q_fmt(e));
            end
            n_checks++;
            if (!inst_valid || pc !== npc || imem_error !== xerr ||
                instruction !== (xerr ? 80'h0 : exp_inst(npc))) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got v=%b pc=%h err=%b inst=%h want pc=%h err=%b inst=%h",
                         it, inst_valid, pc, imem_error, instruction, npc, xerr, xerr ? 80'h0 : exp_inst(npc));
            end
        end
        err_en = 1'b0; ack_delay = 0;
    endtask

    task automatic test_reuse;
        int n;
        logic [63:0] e[$];
        @(negedge clk);
        rst_n = 1'b0;
        reads.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_valid(n);
        reads.delete();
        accept(64'h2);
        wait_valid(n);
`ifdef IFETCH_LINE_REUSE_EN
        e = {};
        n_checks++;
        if (!q_eq(reads, e) || n != 1) begin
            n_fail++; $display("FAIL reuse_same: got reads=%s wait=%0d want none and 1", q_fmt(reads), n);
        end
`else
        e = '{64'h0, 64'h8};
        n_checks++;
        if (!q_eq(reads, e) || n != 2) begin
            n_fail++; $display("FAIL refetch_same: got reads=%s wait=%0d want %s and 2", q_fmt(reads), n, q_fmt(e));
        end
`endif
        n_checks++;
        if (!inst_valid || instruction !== exp_inst(64'h2)) begin
            n_fail++; $display("FAIL same_inst: got v=%b inst=%h want %h", inst_valid, instruction, exp_inst(64'h2));
        end
        reads.delete();
        accept(64'hA);
        wait_valid(n);
`ifdef IFETCH_LINE_REUSE_EN
        e = '{64'h10};
`else
        e = '{64'h8, 64'h10};
`endif
        n_checks++;
        if (!q_eq(reads, e) || !inst_valid || instruction !== exp_inst(64'hA)) begin
            n_fail++;
            $display("FAIL next_line: got reads=%s v=%b inst=%h want reads=%s inst=%h",
                     q_fmt(reads), inst_valid, instruction, q_fmt(e), exp_inst(64'hA));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_offset7();
        test_error();
        test_halt();
        test_delay_reset();
        test_random();
        test_reuse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
